// File: rtl/rotary_pkg.sv
// Shared widths, quadrature state encodings and the transition classifier
// used by the rotary encoder front end.
package rotary_pkg;

  localparam int unsigned POS_WIDTH = 16;
  localparam int unsigned CNT_WIDTH = 16;

  // Quadrature state as {A, B}.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_e;

  typedef enum logic [1:0] {
    MoveNone,
    MoveCw,
    MoveCcw,
    MoveErr
  } move_e;

  // Clockwise successor: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic quad_e quad_cw_next(input quad_e s);
    quad_e n;
    case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      S01:     n = S00;
      default: n = S00;
    endcase
    return n;
  endfunction

  function automatic move_e quad_move(input quad_e prev, input quad_e cur);
    move_e m;
    if (prev == cur) begin
      m = MoveNone;
    end else if ((prev ^ cur) == 2'b11) begin
      m = MoveErr;
    end else if (cur == quad_cw_next(prev)) begin
      m = MoveCw;
    end else begin
      m = MoveCcw;
    end
    return m;
  endfunction

endpackage

// File: rtl/rotary_debounce.sv
// One input channel: two-flop synchronizer followed by a persistence filter
// that adopts the synchronized value only after it has differed for DEBOUNCE_CYCLES.
module rotary_debounce
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 filt_q, filt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      filt_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder with push-button: debounced inputs, step/direction
// decode, wrapping position counter and button press detection.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned DETENT_MODE     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 enc_sw_n,
  input  logic                 clr,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic                 sw_level,
  output logic                 sw_press
);

  logic filt_a, filt_b, filt_sw_n;

  rotary_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0)
  ) u_deb_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (enc_a),
    .filt_o (filt_a)
  );

  rotary_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0)
  ) u_deb_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (enc_b),
    .filt_o (filt_b)
  );

  // Button idles high, so its channel resets to 1 to avoid a press at reset release.
  rotary_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b1)
  ) u_deb_sw (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (enc_sw_n),
    .filt_o (filt_sw_n)
  );

  quad_e                cur_state, prev_q;
  move_e                move;
  logic                 counted;
  logic [POS_WIDTH-1:0] position_q, position_d;
  logic                 step_q, dir_q, dir_d, err_q;
  logic                 sw_level_q, sw_press_q;

  assign cur_state = quad_e'({filt_a, filt_b});
  assign move      = quad_move(prev_q, cur_state);

  // Detent mode only counts arrivals at the 11 rest position.
  assign counted = ((move == MoveCw) || (move == MoveCcw)) &&
                   ((DETENT_MODE == 0) || (cur_state == S11));

  always_comb begin
    position_d = position_q;
    if (clr) begin
      position_d = '0;
    end else if (counted) begin
      position_d = (move == MoveCw) ? position_q + POS_WIDTH'(1)
                                    : position_q - POS_WIDTH'(1);
    end
  end

  assign dir_d = counted ? (move == MoveCw) : dir_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= S00;
      position_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      sw_level_q <= 1'b0;
      sw_press_q <= 1'b0;
    end else begin
      prev_q     <= cur_state;
      position_q <= position_d;
      step_q     <= counted;
      dir_q      <= dir_d;
      err_q      <= (move == MoveErr);
      sw_level_q <= ~filt_sw_n;
      sw_press_q <= ~filt_sw_n & ~sw_level_q;
    end
  end

  assign position = position_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign sw_level = sw_level_q;
  assign sw_press = sw_press_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Self-checking bench: three encoder instances (debounce 4 / detent off,
// debounce 4 / detent on, debounce 1 / detent off) against a quadrature model.
module tb_rotary_decoder;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enc_a = 1'b0, enc_b = 1'b0, enc_sw_n = 1'b1, clr = 1'b0;

  logic [15:0] pos_o  [NDUT];
  logic        step_o [NDUT];
  logic        dir_o  [NDUT];
  logic        err_o  [NDUT];
  logic        lvl_o  [NDUT];
  logic        prs_o  [NDUT];

  always #5 clk = ~clk;

  rotary_decoder #(.DEBOUNCE_CYCLES(4), .DETENT_MODE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_sw_n(enc_sw_n),
    .clr(clr), .position(pos_o[0]), .step(step_o[0]), .dir(dir_o[0]), .err(err_o[0]),
    .sw_level(lvl_o[0]), .sw_press(prs_o[0])
  );

  rotary_decoder #(.DEBOUNCE_CYCLES(4), .DETENT_MODE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_sw_n(enc_sw_n),
    .clr(clr), .position(pos_o[1]), .step(step_o[1]), .dir(dir_o[1]), .err(err_o[1]),
    .sw_level(lvl_o[1]), .sw_press(prs_o[1])
  );

  rotary_decoder #(.DEBOUNCE_CYCLES(1), .DETENT_MODE(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_sw_n(enc_sw_n),
    .clr(clr), .position(pos_o[2]), .step(step_o[2]), .dir(dir_o[2]), .err(err_o[2]),
    .sw_level(lvl_o[2]), .sw_press(prs_o[2])
  );

  int tests = 0;
  int fails = 0;
  int n_step [NDUT];
  int n_err  [NDUT];
  int n_prs  [NDUT];

  // Reference model state; channel index 0 = A, 1 = B, 2 = button.
  int   m_d   [NDUT] = '{4, 4, 1};
  bit   m_det [NDUT] = '{1'b0, 1'b1, 1'b0};
  logic m_s1  [NDUT][3];
  logic m_s2  [NDUT][3];
  logic m_f   [NDUT][3];
  int   m_run [NDUT][3];
  logic [1:0]  m_prev [NDUT];
  logic [15:0] m_pos  [NDUT];
  logic m_step [NDUT], m_dir [NDUT], m_err [NDUT], m_lvl [NDUT], m_prs [NDUT];

  typedef struct {
    logic        a, b, sw_n;
    int          hold;
    logic [15:0] pos0, pos1;
    int          st0, st1, er, pr;
    logic        lvl;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Position of a state along the clockwise cycle 00,10,11,01.
  function automatic int qidx(input logic a, input logic b);
    return a ? (b ? 2 : 1) : (b ? 3 : 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int ch = 0; ch < 3; ch++) begin
        m_s1[k][ch]  = (ch == 2);
        m_s2[k][ch]  = (ch == 2);
        m_f[k][ch]   = (ch == 2);
        m_run[k][ch] = 0;
      end
      m_prev[k] = 2'b00;
      m_pos[k]  = 16'h0000;
      m_step[k] = 1'b0;
      m_dir[k]  = 1'b0;
      m_err[k]  = 1'b0;
      m_lvl[k]  = 1'b0;
      m_prs[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic raw [3];
    raw[0] = enc_a;
    raw[1] = enc_b;
    raw[2] = enc_sw_n;
    for (int k = 0; k < NDUT; k++) begin
      int d;
      bit cnt;
      d = (qidx(m_f[k][0], m_f[k][1]) - qidx(m_prev[k][1], m_prev[k][0]) + 4) % 4;
      cnt = (d == 1 || d == 3) && (!m_det[k] || (m_f[k][0] && m_f[k][1]));
      m_step[k] = cnt;
      if (cnt) m_dir[k] = (d == 1);
      m_err[k] = (d == 2);
      if (clr) m_pos[k] = 16'h0000;
      else if (cnt) m_pos[k] = (d == 1) ? m_pos[k] + 16'd1 : m_pos[k] - 16'd1;
      m_prev[k] = {m_f[k][0], m_f[k][1]};
      m_prs[k] = !m_f[k][2] && !m_lvl[k];
      m_lvl[k] = !m_f[k][2];
      for (int ch = 0; ch < 3; ch++) begin
        if (m_s2[k][ch] != m_f[k][ch]) begin
          if (m_run[k][ch] == m_d[k] - 1) begin
            m_f[k][ch]   = m_s2[k][ch];
            m_run[k][ch] = 0;
          end else begin
            m_run[k][ch]++;
          end
        end else begin
          m_run[k][ch] = 0;
        end
        m_s2[k][ch] = m_s1[k][ch];
        m_s1[k][ch] = raw[ch];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("position", k, 32'(pos_o[k]), 32'(m_pos[k]));
      check("step", k, 32'(step_o[k]), 32'(m_step[k]));
      check("err", k, 32'(err_o[k]), 32'(m_err[k]));
      check("sw_level", k, 32'(lvl_o[k]), 32'(m_lvl[k]));
      check("sw_press", k, 32'(prs_o[k]), 32'(m_prs[k]));
      if (m_step[k]) check("dir", k, 32'(dir_o[k]), 32'(m_dir[k]));
      n_step[k] += int'(step_o[k]);
      n_err[k]  += int'(err_o[k]);
      n_prs[k]  += int'(prs_o[k]);
    end
  endtask

  task automatic hold(input logic a, input logic b, input logic sw_n, input int n);
    enc_a = a;
    enc_b = b;
    enc_sw_n = sw_n;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NDUT; k++) begin
      check("rst_position", k, 32'(pos_o[k]), 32'h0);
      check("rst_step", k, 32'(step_o[k]), 32'h0);
      check("rst_dir", k, 32'(dir_o[k]), 32'h0);
      check("rst_err", k, 32'(err_o[k]), 32'h0);
      check("rst_sw_level", k, 32'(lvl_o[k]), 32'h0);
      check("rst_sw_press", k, 32'(prs_o[k]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One clockwise transition per call: next {A,B} = {~B, A}.
  task automatic cw_walk(input int n);
    for (int i = 0; i < n; i++) begin
      logic na;
      na = ~enc_b;
      enc_b = enc_a;
      enc_a = na;
      tick();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, e0, e1, p0, first, seen;
    logic wrap_dir;
    logic [15:0] wrap_pos;

    for (int k = 0; k < NDUT; k++) begin
      n_step[k] = 0;
      n_err[k]  = 0;
      n_prs[k]  = 0;
    end

    //           a     b     sw    hold pos0      pos1      st0 st1 er pr lvl
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 10, 16'h0001, 16'h0000, 1, 0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 10, 16'h0002, 16'h0001, 1, 1, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 10, 16'h0003, 16'h0001, 1, 0, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 10, 16'h0004, 16'h0001, 1, 0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 10, 16'h0003, 16'h0001, 1, 0, 0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 10, 16'h0002, 16'h0000, 1, 1, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 10, 16'h0002, 16'h0000, 0, 0, 1, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 10, 16'h0002, 16'h0000, 0, 0, 1, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 10, 16'h0001, 16'h0000, 1, 0, 0, 0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 10, 16'h0000, 16'h0000, 1, 0, 0, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 10, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 10, 16'hFFFE, 16'hFFFF, 1, 1, 0, 0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 10, 16'hFFFE, 16'hFFFF, 0, 0, 0, 1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 10, 16'hFFFE, 16'hFFFF, 0, 0, 0, 0, 1'b0};

    #2;
    do_reset();
    hold(1'b0, 1'b0, 1'b1, 8);
    check("idle_after_reset_steps", 0, 32'(n_step[0] + n_err[0] + n_prs[0]), 32'h0);

    for (int i = 0; i < 14; i++) begin
      s0 = n_step[0]; s1 = n_step[1]; e0 = n_err[0]; e1 = n_err[1]; p0 = n_prs[0];
      hold(tbl[i].a, tbl[i].b, tbl[i].sw_n, tbl[i].hold);
      check($sformatf("vec%0d_pos", i), 0, 32'(pos_o[0]), 32'(tbl[i].pos0));
      check($sformatf("vec%0d_pos", i), 1, 32'(pos_o[1]), 32'(tbl[i].pos1));
      check($sformatf("vec%0d_steps", i), 0, 32'(n_step[0] - s0), 32'(tbl[i].st0));
      check($sformatf("vec%0d_steps", i), 1, 32'(n_step[1] - s1), 32'(tbl[i].st1));
      check($sformatf("vec%0d_errs", i), 0, 32'(n_err[0] - e0), 32'(tbl[i].er));
      check($sformatf("vec%0d_errs", i), 1, 32'(n_err[1] - e1), 32'(tbl[i].er));
      check($sformatf("vec%0d_press", i), 0, 32'(n_prs[0] - p0), 32'(tbl[i].pr));
      check($sformatf("vec%0d_level", i), 0, 32'(lvl_o[0]), 32'(tbl[i].lvl));
    end

    // Back to 00 via two clockwise steps, then a short glitch on A.
    hold(1'b0, 1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 1'b1, 10);
    check("rest_pos", 0, 32'(pos_o[0]), 32'h0000);
    s0 = n_step[0];
    hold(1'b1, 1'b0, 1'b1, 3);
    hold(1'b0, 1'b0, 1'b1, 12);
    check("glitch_steps", 0, 32'(n_step[0] - s0), 32'h0);
    check("glitch_pos", 0, 32'(pos_o[0]), 32'h0000);

    first = 0;
    enc_a = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      if (t == 5) enc_a = 1'b0;
      tick();
      if (step_o[0] && first == 0) first = t;
    end
    check("latency_4cycle_pulse", 0, 32'(first), 32'd7);
    hold(1'b0, 1'b0, 1'b1, 12);
    check("pulse_return_pos", 0, 32'(pos_o[0]), 32'h0000);

    // Clear lands on the same edge as a step.
    enc_a = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_step_pulse", 0, 32'(step_o[0]), 32'h1);
    check("clr_step_pos", 0, 32'(pos_o[0]), 32'h0000);
    check("clr_step_pos", 1, 32'(pos_o[1]), 32'h0000);
    p0 = n_prs[0];
    hold(1'b1, 1'b0, 1'b0, 10);
    check("btn_press_count", 0, 32'(n_prs[0] - p0), 32'h1);
    check("btn_level", 0, 32'(lvl_o[0]), 32'h1);
    check("btn_pos", 0, 32'(pos_o[0]), 32'h0000);
    hold(1'b1, 1'b0, 1'b1, 10);

    // Reset in the middle of a debounce count must restart the count.
    hold(1'b0, 1'b0, 1'b1, 10);
    enc_a = 1'b1;
    repeat (4) tick();
    do_reset();
    first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (step_o[0] && first == 0) first = t;
    end
    check("latency_after_reset", 0, 32'(first), 32'd7);

    // Wrap 0x7FFF -> 0x8000 on the fast instance.
    hold(1'b1, 1'b0, 1'b1, 10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("walk_clr_pos", 2, 32'(pos_o[2]), 32'h0000);
    cw_walk(32767);
    repeat (6) tick();
    check("walk_pos", 2, 32'(pos_o[2]), 32'h7FFF);
    cw_walk(1);
    seen = 0;
    wrap_dir = 1'b0;
    wrap_pos = 16'h0000;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (step_o[2] && seen == 0) begin
        seen = 1;
        wrap_dir = dir_o[2];
        wrap_pos = pos_o[2];
      end
    end
    check("wrap_step_seen", 2, 32'(seen), 32'h1);
    check("wrap_dir", 2, 32'(wrap_dir), 32'h1);
    check("wrap_pos", 2, 32'(wrap_pos), 32'h8000);

    // Random segments against the model.
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 15) == 0);
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 12)));
    end
    clr = 1'b0;
    hold(1'b0, 1'b0, 1'b1, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
